// File: rtl/bc_pkg.sv
// Shared types and helpers for the bulls-and-cows round controller.
package bc_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    SCORE,
    REPORT,
    WON,
    LOST
  } state_t;

  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [9:0] onehot);
    logic [DIGIT_W-1:0] bcd;
    bcd = '0;
    for (int i = 0; i < 10; i++) begin
      if (onehot[i]) bcd = DIGIT_W'(i);
    end
    return bcd;
  endfunction

endpackage

// File: rtl/bc_key_edge.sv
// Keypad front end: registers the level inputs, reports single-cycle rising
// edges, and rejects digit events where several keys rise together.
module bc_key_edge
  import bc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         key,
  input  logic               key_clr,
  input  logic               key_enter,
  output logic               digit_evt,
  output logic [DIGIT_W-1:0] digit_bcd,
  output logic               clr_evt,
  output logic               enter_evt
);

  logic [9:0] key_q;
  logic       clr_q;
  logic       enter_q;
  logic [9:0] key_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      clr_q   <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      key_q   <= key;
      clr_q   <= key_clr;
      enter_q <= key_enter;
    end
  end

  assign key_rise = key & ~key_q;

  // Exactly one rising bit is a valid digit; zero or several are discarded.
  assign digit_evt = (key_rise != '0) && ((key_rise & (key_rise - 10'd1)) == '0);
  assign digit_bcd = onehot_to_bcd(key_rise);
  assign clr_evt   = key_clr & ~clr_q;
  assign enter_evt = key_enter & ~enter_q;

endmodule

// File: rtl/bulls_cows_round_ctrl.sv
// Bulls-and-cows round controller: keypad guess entry, one-position-per-cycle
// scoring against a latched answer, try accounting and win/lose states.
module bulls_cows_round_ctrl
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_TRIES  = 10,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    key,
  input  logic                          key_clr,
  input  logic                          key_enter,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] answer,
  input  logic                          answer_load,
  output logic [DIGIT_W*NUM_DIGITS-1:0] guess_echo,
  output logic [CW-1:0]                 entry_count,
  output logic [CW-1:0]                 strike,
  output logic [CW-1:0]                 ball,
  output logic [NUM_DIGITS-1:0]         hit,
  output logic [NUM_DIGITS-1:0]         near,
  output logic                          result_valid,
  output logic [TW-1:0]                 tries_left,
  output logic                          win,
  output logic                          lose,
  output logic                          busy
);

  localparam int BW = DIGIT_W * NUM_DIGITS;
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_t state, next_state;

  logic [BW-1:0]         ans_q, guess_q;
  logic [CW-1:0]         cnt_q, idx_q;
  logic [CW-1:0]         acc_strike, acc_ball, strike_q, ball_q;
  logic [NUM_DIGITS-1:0] acc_hit, acc_near, hit_q, near_q;
  logic [TW-1:0]         tries_q;

  logic               digit_evt, clr_evt, enter_evt;
  logic [DIGIT_W-1:0] digit_bcd;
  logic               buf_full, digit_dup;

  logic [DIGIT_W-1:0]    cur_guess, cur_ans;
  logic                  pos_strike, pos_ball, ans_has;
  logic [CW-1:0]         strike_nxt, ball_nxt;
  logic [NUM_DIGITS-1:0] hit_nxt, near_nxt;

  bc_key_edge u_key_edge (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_clr   (key_clr),
    .key_enter (key_enter),
    .digit_evt (digit_evt),
    .digit_bcd (digit_bcd),
    .clr_evt   (clr_evt),
    .enter_evt (enter_evt)
  );

  // Position 0 lives in the most significant nibble; BLANK never matches a key.
  always_comb begin
    digit_dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (guess_q[BW-DIGIT_W*(i+1) +: DIGIT_W] == digit_bcd) digit_dup = 1'b1;
    end
  end

  assign buf_full = (cnt_q == FULL);

  always_comb begin
    cur_guess = BLANK;
    cur_ans   = BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CW'(i) == idx_q) begin
        cur_guess = guess_q[BW-DIGIT_W*(i+1) +: DIGIT_W];
        cur_ans   = ans_q[BW-DIGIT_W*(i+1) +: DIGIT_W];
      end
    end
    ans_has = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((CW'(j) != idx_q) && (ans_q[BW-DIGIT_W*(j+1) +: DIGIT_W] == cur_guess)) ans_has = 1'b1;
    end
    pos_strike = (cur_guess == cur_ans);
    pos_ball   = !pos_strike && ans_has;
    strike_nxt = acc_strike + CW'(pos_strike);
    ball_nxt   = acc_ball + CW'(pos_ball);
    hit_nxt    = acc_hit | (NUM_DIGITS'(pos_strike) << idx_q);
    near_nxt   = acc_near | (NUM_DIGITS'(pos_ball) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (answer_load) begin
      next_state = ENTRY;
    end else begin
      case (state)
        ENTRY:   if (!clr_evt && enter_evt && buf_full) next_state = SCORE;
        SCORE:   if (idx_q == LAST) next_state = REPORT;
        REPORT: begin
          if (strike_q == FULL)    next_state = WON;
          else if (tries_q == '0)  next_state = LOST;
          else                     next_state = ENTRY;
        end
        IDLE, WON, LOST: next_state = state;
        default: next_state = IDLE;
      endcase
    end
  end

  // Masks use bit i for position i; the held score only changes on the last scoring cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ans_q      <= '0;
      guess_q    <= {NUM_DIGITS{BLANK}};
      cnt_q      <= '0;
      idx_q      <= '0;
      acc_strike <= '0;
      acc_ball   <= '0;
      acc_hit    <= '0;
      acc_near   <= '0;
      strike_q   <= '0;
      ball_q     <= '0;
      hit_q      <= '0;
      near_q     <= '0;
      tries_q    <= '0;
    end else if (answer_load) begin
      ans_q      <= answer;
      guess_q    <= {NUM_DIGITS{BLANK}};
      cnt_q      <= '0;
      idx_q      <= '0;
      acc_strike <= '0;
      acc_ball   <= '0;
      acc_hit    <= '0;
      acc_near   <= '0;
      strike_q   <= '0;
      ball_q     <= '0;
      hit_q      <= '0;
      near_q     <= '0;
      tries_q    <= TW'(MAX_TRIES);
    end else begin
      case (state)
        ENTRY: begin
          if (clr_evt) begin
            guess_q <= {NUM_DIGITS{BLANK}};
            cnt_q   <= '0;
          end else if (enter_evt && buf_full) begin
            idx_q      <= '0;
            acc_strike <= '0;
            acc_ball   <= '0;
            acc_hit    <= '0;
            acc_near   <= '0;
          end else if (digit_evt && !buf_full && !digit_dup) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (CW'(i) == cnt_q) guess_q[BW-DIGIT_W*(i+1) +: DIGIT_W] <= digit_bcd;
            end
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SCORE: begin
          idx_q      <= idx_q + CW'(1);
          acc_strike <= strike_nxt;
          acc_ball   <= ball_nxt;
          acc_hit    <= hit_nxt;
          acc_near   <= near_nxt;
          if (idx_q == LAST) begin
            strike_q <= strike_nxt;
            ball_q   <= ball_nxt;
            hit_q    <= hit_nxt;
            near_q   <= near_nxt;
            tries_q  <= tries_q - TW'(1);
          end
        end
        REPORT: begin
          if (next_state == ENTRY) begin
            guess_q <= {NUM_DIGITS{BLANK}};
            cnt_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign guess_echo   = guess_q;
  assign entry_count  = cnt_q;
  assign strike       = strike_q;
  assign ball         = ball_q;
  assign hit          = hit_q;
  assign near         = near_q;
  assign tries_left   = tries_q;
  assign result_valid = (state == REPORT);
  assign win          = (state == WON);
  assign lose         = (state == LOST);
  assign busy         = (state == SCORE) || (state == REPORT);

endmodule

// File: doc/bulls_cows_round_ctrl.md
BULLS_COWS_ROUND_CTRL -- requirements
Module: bulls_cows_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning digits per code (2..8).
REQ-002 SHALL have parameter MAX_TRIES, default 10, meaning guesses allowed per round (1..15).
REQ-003 SHALL define derived widths: CW = clog2(NUM_DIGITS+1) and TW = clog2(MAX_TRIES+1).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 key  in  10  level keypad; bit i = decimal digit i.
REQ-007 key_clr  in  1  level; clears entry buffer.
REQ-008 key_enter  in  1  level; submits guess.
REQ-009 answer  in  4*NUM_DIGITS  BCD code; digit 0 in MSBs.
REQ-010 answer_load  in  1  pulse; latches answer and starts a new round.
REQ-011 guess_echo  out  4*NUM_DIGITS  entry buffer; unentered digits read 0xF.
REQ-012 entry_count  out  CW  digits entered.
REQ-013 strike / ball  out  CW each  last score, held.
REQ-014 hit / near  out  NUM_DIGITS each  per-position strike / ball masks, held.
REQ-015 result_valid  out  1  one-cycle pulse when a new score is presented.
REQ-016 tries_left  out  TW  remaining guesses.
REQ-017 win / lose / busy  out  1 each  terminal flags; busy high in SCORE and REPORT.

Function
REQ-018 SHALL register key, key_clr and key_enter and act only on rising edges (0->1 versus previous cycle).
REQ-019 SHALL ignore a key event when more than one key bit rises in the same cycle.
REQ-020 SHALL implement states IDLE, ENTRY, SCORE, REPORT, WON, LOST.
REQ-021 In ENTRY, a single digit edge SHALL append at position entry_count and increment it.
REQ-022 A digit edge SHALL be ignored if the buffer is full or the digit is already in the buffer.
REQ-023 A key_clr edge in ENTRY SHALL reset the buffer to all 0xF and entry_count to 0.
REQ-024 If key_clr and a digit edge occur in the same cycle, clear SHALL win.
REQ-025 A key_enter edge in ENTRY with entry_count==NUM_DIGITS, at cycle T, SHALL enter SCORE at T+1.
REQ-026 A key_enter edge with entry_count<NUM_DIGITS SHALL be ignored.
REQ-027 SCORE SHALL take exactly NUM_DIGITS cycles, evaluating guess position i in cycle T+1+i.
REQ-028 Position i SHALL count as a strike if guess[i]==answer[i].
REQ-029 Otherwise position i SHALL count as a ball if guess[i] equals answer[j] for any j != i.
REQ-030 strike and ball SHALL never exceed NUM_DIGITS.
REQ-031 In REPORT (cycle T+NUM_DIGITS+1), result_valid SHALL pulse, strike/ball/hit/near SHALL update, and tries_left SHALL decrement.
REQ-032 After REPORT: go to WON if strike==NUM_DIGITS, else LOST if tries_left reaches 0, else ENTRY with the buffer cleared.
REQ-033 All key events in SCORE, REPORT, WON, LOST and IDLE SHALL be ignored.
REQ-034 answer_load in any non-reset state SHALL latch answer, set tries_left=MAX_TRIES, clear buffer, score, masks, win and lose, and enter ENTRY next cycle.
REQ-035 answer_load SHALL take priority over any simultaneous key event.
REQ-036 answer_load arriving mid-SCORE SHALL abort scoring without pulsing result_valid.
REQ-037 win SHALL be high only in WON and lose only in LOST; both states SHALL hold until answer_load or rst.
REQ-038 answer SHALL be used only from its latched copy; non-BCD or duplicate-digit answers SHALL be scored per REQ-028/029 without error.

Reset
REQ-039 While rst is high at a clock edge: state=IDLE, entry_count=0, guess_echo all 0xF, strike=ball=0, hit=near=0, result_valid=0, tries_left=0, win=lose=busy=0, latched answer=0, edge registers=0.
REQ-040 rst SHALL take priority over answer_load and abort any operation.

Structure
REQ-041 Shared package bc_pkg SHALL hold the state enumeration, DIGIT_W=4, the BLANK=0xF constant and the one-hot-to-BCD encode function.
REQ-042 One sub-module, bc_key_edge, SHALL perform key registering, rising-edge detection, the multi-key reject and BCD encoding.

Verification
REQ-043 answer=0x1234 loaded; keys 1,2,3,4; enter -> result_valid exactly 5 cycles after the enter edge, strike=4, ball=0, hit=1111, win=1.
REQ-044 answer=0x1234; guess 4,3,2,1 -> strike=0, ball=4, near=1111, tries_left=9, state back to ENTRY.
REQ-045 Entry 5,5,6 -> entry_count=2; enter -> ignored; key_clr -> guess_echo=0xFFFF, entry_count=0.
REQ-046 MAX_TRIES=2; two wrong guesses (5678, 5679) -> after the second, lose=1 and tries_left=0; further keys have no effect.
REQ-047 answer_load asserted 2 cycles into SCORE -> no result_valid, tries_left=MAX_TRIES, state ENTRY.
REQ-048 NUM_DIGITS=3 build, answer=0x120 (digits 1,2,0), guess 0,2,1 -> strike=1, ball=2; keys 2 and 7 rising together -> ignored.
